linear_layer_start_fifo_ctrl: RTL and testbench
===============================================

LINEAR_LAYER_START_FIFO_CTRL -- requirements
Module: linear_layer_start_fifo_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 1, payload width in bits.
REQ-002 Parameter ADDR_WIDTH, default 1, shift-register address width; SHALL satisfy 2**ADDR_WIDTH >= DEPTH.
REQ-003 Parameter DEPTH, default 2, shift-register storage entries (>= 2).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 ap_rst_n  input  1  reset, synchronous, active-low.
REQ-006 if_full_n  output  1  high when a write will be accepted.
REQ-007 if_write_ce  input  1  write-side clock enable; gates if_write.
REQ-008 if_write  input  1  write request.
REQ-009 if_din  input  DATA_WIDTH  write data.
REQ-010 if_empty_n  output  1  high when if_dout holds a valid word.
REQ-011 if_read_ce  input  1  read-side clock enable; gates if_read.
REQ-012 if_read  input  1  read request; consumes the word on if_dout.
REQ-013 if_dout  output  DATA_WIDTH  registered head-of-queue data.

Function
REQ-014 Write accepted (push) SHALL equal if_write_ce & if_write & if_full_n; pushes when if_full_n=0 SHALL be dropped with no state change.
REQ-015 Read accepted (pop) SHALL equal if_read_ce & if_read & if_empty_n; pops when if_empty_n=0 SHALL be ignored.
REQ-016 Storage SHALL be a DEPTH-entry shift register: push shifts all entries one slot and inserts if_din at slot 0; read address = count-1 selects the oldest entry.
REQ-017 Occupancy counter count (0..DEPTH) SHALL update: push only +1; load of output register only -1; both -> unchanged.
REQ-018 Output stage SHALL be one register (out_data, out_valid); if_dout = out_data, if_empty_n = out_valid.
REQ-019 Load SHALL occur when count>0 and (out_valid=0 or pop); load copies entry at address count-1 to out_data, sets out_valid=1.
REQ-020 Pop without load SHALL clear out_valid; out_data holds its last value.
REQ-021 if_full_n SHALL be registered and equal (next count < DEPTH), counting a simultaneous load as freeing one slot.
REQ-022 Total capacity SHALL be DEPTH+1 words; ordering strictly FIFO.
REQ-023 Latency: push into fully empty block at cycle N SHALL yield if_empty_n=1 with that word on if_dout at cycle N+2.
REQ-024 Full with simultaneous pop: if_full_n SHALL rise the cycle after the pop; a push presented while if_full_n=0 in that same cycle is dropped.
REQ-025 Sustained push+pop at one word/cycle SHALL be supported once if_empty_n=1 and if_full_n=1, with count constant.

Reset
REQ-026 When ap_rst_n=0 at a clock edge: count=0, out_valid=0, out_data=0, if_full_n=1, if_empty_n=0; shift-register contents need no reset.
REQ-027 Reset asserted mid-operation SHALL discard all stored and output words; the first push after release follows REQ-023 timing.
REQ-028 Pushes and pops during reset SHALL have no effect.

Structure
REQ-029 The shift-register storage SHALL be one sub-module, linear_layer_start_fifo_srl (clk, we, addr, din, dout; no reset), instantiated once.
REQ-030 No shared package is required; DATA_WIDTH/ADDR_WIDTH/DEPTH remain module parameters; count width is ADDR_WIDTH+1.

Verification (DEPTH=2, DATA_WIDTH=8)
REQ-031 Reset then idle -> if_full_n=1, if_empty_n=0, if_dout=0 for all cycles.
REQ-032 Push 0xA5 at cycle 0, no reads -> if_empty_n=1, if_dout=0xA5 at cycle 2; stays until popped.
REQ-033 Push 0x01,0x02,0x03,0x04 back-to-back, no reads -> first three accepted, if_full_n=0 after third; 0x04 dropped; pops return 0x01,0x02,0x03 then if_empty_n=0.
REQ-034 When full, assert pop and push 0x10 in one cycle -> push dropped, if_full_n=1 next cycle; push 0x10 then accepted and read fourth.
REQ-035 Continuous push 0x00..0x0F with if_read=1 throughout -> outputs 0x00..0x0F in order, no drops, if_full_n never 0.
REQ-036 Three words stored, ap_rst_n=0 one cycle -> if_empty_n=0, if_full_n=1 next cycle; later push 0x77 appears 2 cycles after acceptance.

Source files
------------

// File: rtl/linear_layer_start_fifo_ctrl_pkg.sv
// Shared types for the start-FIFO controller: classification of how the
// occupancy counter moves in a given cycle.
package linear_layer_start_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } count_op_e;

  // A push and a load in the same cycle cancel out.
  function automatic count_op_e count_op(input logic push, input logic load);
    if (push && !load) return CNT_INC;
    if (load && !push) return CNT_DEC;
    return CNT_HOLD;
  endfunction

endpackage

// File: rtl/linear_layer_start_fifo_srl.sv
// Shift-register storage for the start FIFO: a write shifts every entry one
// slot deeper and inserts the new word at slot 0. No reset on the contents.
module linear_layer_start_fifo_srl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  // Addresses beyond the storage only occur when the queue is empty.
  always_comb begin
    dout = '0;
    if ({1'b0, addr} < DEPTH_C) begin
      dout = mem[addr];
    end
  end

endmodule

// File: rtl/linear_layer_start_fifo_ctrl.sv
// Start FIFO controller: DEPTH-entry shift-register queue followed by one
// registered output word, giving DEPTH+1 words of FIFO capacity.
module linear_layer_start_fifo_ctrl
  import linear_layer_start_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  ap_rst_n,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  full_n_r;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [DATA_WIDTH-1:0] srl_dout;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  push;
  logic                  pop;
  logic                  load;

  assign push = if_write_ce & if_write & full_n_r;
  assign pop  = if_read_ce & if_read & out_valid;
  assign load = (count != '0) && (!out_valid || pop);

  // Newest word sits at slot 0, so the oldest is at count-1.
  assign rd_addr = count[ADDR_WIDTH-1:0] - ADDR_ONE;

  linear_layer_start_fifo_srl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk  (clk),
    .we   (push & ap_rst_n),
    .addr (rd_addr),
    .din  (if_din),
    .dout (srl_dout)
  );

  always_comb begin
    count_next = count;
    case (count_op(push, load))
      CNT_INC: count_next = count + COUNT_ONE;
      CNT_DEC: count_next = count - COUNT_ONE;
      default: count_next = count;
    endcase
  end

  // full_n looks at the post-update count so a same-cycle load frees a slot.
  always_ff @(posedge clk) begin
    if (!ap_rst_n) begin
      count     <= '0;
      full_n_r  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      count    <= count_next;
      full_n_r <= (count_next < DEPTH_C);
      if (load) begin
        out_data  <= srl_dout;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign if_full_n  = full_n_r;
  assign if_empty_n = out_valid;
  assign if_dout    = out_data;

endmodule

// File: tb/tb_linear_layer_start_fifo_ctrl.sv
// Self-checking bench for the start FIFO: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_linear_layer_start_fifo_ctrl;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 1;
  localparam int DEPTH      = 2;

  logic                  clk = 1'b0;
  logic                  ap_rst_n;
  logic                  if_full_n;
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_empty_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;

  int n_asserts = 0;
  int n_fails   = 0;

  // Reference model: words not yet handed to the output, plus the output slot.
  logic [DATA_WIDTH-1:0] q[$];
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_dout;
  logic                  m_full_n;

  linear_layer_start_fifo_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .ap_rst_n    (ap_rst_n),
    .if_full_n   (if_full_n),
    .if_write_ce (if_write_ce),
    .if_write    (if_write),
    .if_din      (if_din),
    .if_empty_n  (if_empty_n),
    .if_read_ce  (if_read_ce),
    .if_read     (if_read),
    .if_dout     (if_dout)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    q.delete();
    m_valid  = 1'b0;
    m_dout   = '0;
    m_full_n = 1'b1;
  endtask

  task automatic modelStep();
    bit acc_w;
    bit acc_r;
    if (!ap_rst_n) begin
      modelReset();
    end else begin
      acc_w = if_write_ce && if_write && m_full_n;
      acc_r = if_read_ce && if_read && m_valid;
      if (q.size() > 0 && (!m_valid || acc_r)) begin
        m_dout  = q.pop_front();
        m_valid = 1'b1;
      end else if (acc_r) begin
        m_valid = 1'b0;
      end
      if (acc_w) q.push_back(if_din);
      m_full_n = (q.size() < DEPTH);
    end
  endtask

  task automatic checkValue(input string tag, input logic [DATA_WIDTH-1:0] obs,
                            input logic [DATA_WIDTH-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("full_n", 8'(if_full_n), 8'(m_full_n));
    checkValue("empty_n", 8'(if_empty_n), 8'(m_valid));
    checkValue("dout", if_dout, m_dout);
  endtask

  // Inputs are held for one full cycle; outputs are checked at the falling edge.
  task automatic applyStimulus(input logic rst_n, input logic wce, input logic w,
                               input logic [DATA_WIDTH-1:0] din,
                               input logic rce, input logic r);
    ap_rst_n    = rst_n;
    if_write_ce = wce;
    if_write    = w;
    if_din      = din;
    if_read_ce  = rce;
    if_read     = r;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  initial begin
    ap_rst_n    = 1'b0;
    if_write_ce = 1'b0;
    if_write    = 1'b0;
    if_din      = '0;
    if_read_ce  = 1'b0;
    if_read     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    // Idle after reset.
    repeat (3) applyStimulus(1, 0, 0, 8'h00, 0, 0);

    // Single push, visible two cycles later and held until popped.
    applyStimulus(1, 1, 1, 8'hA5, 0, 0);
    applyStimulus(1, 0, 0, 8'h00, 0, 0);
    checkValue("a5_empty_n", 8'(if_empty_n), 8'h01);
    checkValue("a5_dout", if_dout, 8'hA5);
    repeat (3) applyStimulus(1, 0, 0, 8'h00, 0, 0);
    checkValue("a5_hold", if_dout, 8'hA5);
    applyStimulus(1, 0, 0, 8'h00, 1, 1);
    applyStimulus(1, 0, 0, 8'h00, 0, 0);

    // Fill to capacity; the fourth push is dropped.
    applyStimulus(0, 0, 0, 8'h00, 0, 0);
    applyStimulus(1, 1, 1, 8'h01, 0, 0);
    applyStimulus(1, 1, 1, 8'h02, 0, 0);
    applyStimulus(1, 1, 1, 8'h03, 0, 0);
    checkValue("fill_full_n", 8'(if_full_n), 8'h00);
    applyStimulus(1, 1, 1, 8'h04, 0, 0);
    checkValue("fill_dout", if_dout, 8'h01);

    // Pop while full: concurrent push dropped, full_n rises, retry accepted.
    applyStimulus(1, 1, 1, 8'h10, 1, 1);
    checkValue("popfull_full_n", 8'(if_full_n), 8'h01);
    applyStimulus(1, 1, 1, 8'h10, 0, 0);
    checkValue("drain_2", if_dout, 8'h02);
    applyStimulus(1, 0, 0, 8'h00, 1, 1);
    checkValue("drain_3", if_dout, 8'h03);
    applyStimulus(1, 0, 0, 8'h00, 1, 1);
    checkValue("drain_10", if_dout, 8'h10);
    applyStimulus(1, 0, 0, 8'h00, 1, 1);
    checkValue("drain_empty_n", 8'(if_empty_n), 8'h00);
    applyStimulus(1, 0, 0, 8'h00, 0, 0);

    // Streaming push and pop every cycle.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 1, 1, 8'(i), 1, 1);
      checkValue("stream_full_n", 8'(if_full_n), 8'h01);
    end
    repeat (3) applyStimulus(1, 0, 0, 8'h00, 1, 1);

    // Reset with data stored, then a fresh push.
    applyStimulus(1, 1, 1, 8'h31, 0, 0);
    applyStimulus(1, 1, 1, 8'h32, 0, 0);
    applyStimulus(1, 1, 1, 8'h33, 0, 0);
    applyStimulus(0, 1, 1, 8'h44, 1, 1);
    checkValue("rst_empty_n", 8'(if_empty_n), 8'h00);
    checkValue("rst_full_n", 8'(if_full_n), 8'h01);
    applyStimulus(1, 1, 1, 8'h77, 0, 0);
    applyStimulus(1, 0, 0, 8'h00, 0, 0);
    checkValue("post_rst_empty_n", 8'(if_empty_n), 8'h01);
    checkValue("post_rst_dout", if_dout, 8'h77);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 49) != 0),
                    ($urandom_range(0, 3) != 0),
                    1'($urandom),
                    8'($urandom),
                    ($urandom_range(0, 3) != 0),
                    1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
